// File: rtl/gf_inv_seq.sv
// GF(2^8) multiplicative inverse by square-and-multiply (a^254).
// The block uses one shared combinational multiply-and-reduce, taking 7 SQR/MUL pairs per operand.
//
// state | meaning
// IDLE  | waiting for start; operands sampled here
// SQR   | base <= base*base
// MUL   | acc <= acc*base; the last pass (cnt==6) writes inv_out/zero_err
// DONE  | done pulse for one cycle, then back to IDLE
module gf_inv_seq #(
   parameter logic [7:0] DEFAULT_POLY = 8'h1B
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] a_in,
   input  logic [7:0] poly_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] inv_out,
   output logic       zero_err
);

   typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

   state_t     state, state_nxt;
   logic [7:0] base, acc, poly_r;
   logic [2:0] cnt;
   logic       zflag;
   logic [7:0] mul_a, mul_res;

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y,
                                         input logic [7:0] p);
      logic [14:0] prod;
      prod = '0;
      for (int i = 0; i < 8; i++)
         if (y[i]) prod = prod ^ (15'(x) << i);
      // fold bits 14..8 back down, highest first
      for (int i = 14; i >= 8; i--)
         if (prod[i]) prod = prod ^ (15'({1'b1, p}) << (i - 8));
      return prod[7:0];
   endfunction

   assign mul_a   = (state == MUL) ? acc : base;
   assign mul_res = gf_mul(mul_a, base, poly_r);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SQR;
         SQR:     state_nxt = MUL;
         MUL:     state_nxt = (cnt == 3'd6) ? DONE : SQR;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base     <= 8'h00;
         acc      <= 8'h01;
         cnt      <= 3'd0;
         poly_r   <= DEFAULT_POLY;
         zflag    <= 1'b0;
         inv_out  <= 8'h00;
         zero_err <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               base   <= a_in;
               acc    <= 8'h01;
               cnt    <= 3'd0;
               poly_r <= (poly_in == 8'h00) ? DEFAULT_POLY : poly_in;
               zflag  <= (a_in == 8'h00);
            end
            SQR: base <= mul_res;
            MUL: begin
               acc <= mul_res;
               cnt <= cnt + 3'd1;
               if (cnt == 3'd6) begin
                  inv_out  <= mul_res;
                  zero_err <= zflag;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gf_inv_seq.sv
// Self-checking bench for gf_inv_seq: directed vectors, corner sequences,
// random operands/polynomials against an exponentiation model, and a full inverse sweep.
module tb_gf_inv_seq;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a_in = 8'h00;
   logic [7:0] poly_in = 8'h00;
   logic       busy, done, zero_err;
   logic [7:0] inv_out;

   int n_tests = 0;
   int n_fail  = 0;

   gf_inv_seq #(.DEFAULT_POLY(8'h1B)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .poly_in(poly_in),
      .busy(busy), .done(done), .inv_out(inv_out), .zero_err(zero_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] poly;
      logic [7:0] exp_inv;
      logic       exp_zero;
   } vec_t;

   // shift-and-add multiply: reduce on every doubling of the multiplicand
   function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                          input logic [7:0] p);
      logic [7:0] r, xx, pp;
      r  = 8'h00;
      xx = x;
      pp = (p == 8'h00) ? 8'h1B : p;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) r = r ^ xx;
         xx = xx[7] ? ((xx << 1) ^ pp) : (xx << 1);
      end
      return r;
   endfunction

   // a^254 as 253 plain repeated multiplications
   function automatic logic [7:0] ref_pow254(input logic [7:0] x, input logic [7:0] p);
      logic [7:0] r;
      r = x;
      for (int i = 0; i < 253; i++) r = ref_mul(r, x, p);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_op(input logic [7:0] a, input logic [7:0] p,
                        output logic [7:0] inv, output logic z, output int lat);
      @(negedge clk);
      start = 1'b1; a_in = a; poly_in = p;
      @(posedge clk); #1;
      start = 1'b0; a_in = 8'($urandom); poly_in = 8'($urandom);
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      inv = inv_out;
      z   = zero_err;
      @(posedge clk); #1;
      chk("done_fall", {31'd0, done}, 32'd0);
      chk("busy_fall", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      vec_t       vecs[6];
      logic [7:0] inv, ea;
      logic       z;
      int         lat, ndone;

      vecs[0] = '{8'h53, 8'h1B, 8'hCA, 1'b0};
      vecs[1] = '{8'h02, 8'h00, 8'h8D, 1'b0};
      vecs[2] = '{8'h01, 8'h1B, 8'h01, 1'b0};
      vecs[3] = '{8'h00, 8'h1B, 8'h00, 1'b1};
      vecs[4] = '{8'h03, 8'h1B, 8'hF6, 1'b0};
      vecs[5] = '{8'h01, 8'h00, 8'h01, 1'b0};

      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_inv", {24'd0, inv_out}, 32'd0);
      chk("rst_zero", {31'd0, zero_err}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         do_op(vecs[i].a, vecs[i].poly, inv, z, lat);
         chk("vec_lat", lat, 14);
         chk("vec_inv", {24'd0, inv}, {24'd0, vecs[i].exp_inv});
         chk("vec_zero", {31'd0, z}, {31'd0, vecs[i].exp_zero});
      end

      // start pulses during the run and during DONE must be ignored
      @(negedge clk); start = 1'b1; a_in = 8'h53; poly_in = 8'h1B;
      @(posedge clk); #1; start = 1'b0;
      ndone = 0;
      for (int e = 1; e <= 14; e++) begin
         if (e == 5) begin start = 1'b1; a_in = 8'h02; end
         else start = 1'b0;
         @(posedge clk); #1;
         chk("ign_busy", {31'd0, busy}, 32'd1);
         if (done) ndone++;
      end
      chk("ign_inv", {24'd0, inv_out}, 32'hCA);
      start = 1'b1; a_in = 8'h02;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) ndone++;
      chk("ign_ndone", ndone, 1);
      chk("ign_idle", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk("ign_stay", {31'd0, busy}, 32'd0);
      chk("ign_hold", {24'd0, inv_out}, 32'hCA);

      // reset mid-run, start held through release
      @(negedge clk); start = 1'b1; a_in = 8'h53; poly_in = 8'h1B;
      @(posedge clk); #1; start = 1'b0;
      repeat (7) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_inv", {24'd0, inv_out}, 32'd0);
      start = 1'b1; a_in = 8'h02; poly_in = 8'h00;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("rel_busy", {31'd0, busy}, 32'd1);
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("rel_lat", lat, 14);
      chk("rel_inv", {24'd0, inv_out}, 32'h8D);
      @(posedge clk); #1;

      // random operands and polynomials against the exponentiation model
      for (int i = 0; i < 30; i++) begin
         logic [7:0] ra, rp;
         ra = 8'($urandom);
         rp = (i % 4 == 0) ? 8'h00 : 8'($urandom);
         if (i % 7 == 0) ra = 8'h00;
         do_op(ra, rp, inv, z, lat);
         ea = (ra == 8'h00) ? 8'h00 : ref_pow254(ra, rp);
         chk("rnd_lat", lat, 14);
         chk("rnd_inv", {24'd0, inv}, {24'd0, ea});
         chk("rnd_zero", {31'd0, z}, {31'd0, (ra == 8'h00)});
      end

      // every nonzero element times its inverse is one
      for (int a = 1; a < 256; a++) begin
         do_op(8'(a), 8'h1B, inv, z, lat);
         chk("sweep", {24'd0, ref_mul(8'(a), inv, 8'h1B)}, 32'h01);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
